// File: rtl/pixel_swap_ctrl.sv
// Pixel stream channel permuter with frame tracking. Swaps the R/G/B byte order per frame,
// regenerates sof/eol from internal counters and flags marker mismatches.
module pixel_swap_ctrl #(
  parameter int H_PIX   = 1280,
  parameter int V_LINES = 720
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  cfg_mode,
  input  logic        cfg_valid,
  input  logic [23:0] s_pixel,
  input  logic        s_valid,
  input  logic        s_sof,
  input  logic        s_eol,
  output logic        s_ready,
  output logic [23:0] m_pixel,
  output logic        m_valid,
  output logic        m_sof,
  output logic        m_eol,
  input  logic        m_ready,
  output logic [2:0]  mode_active,
  output logic        busy,
  output logic        frame_done,
  output logic        err_sync
);
  localparam int XW = (H_PIX > 1) ? $clog2(H_PIX) : 1;
  localparam int YW = (V_LINES > 1) ? $clog2(V_LINES) : 1;
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACTIVE = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [2:0]    pend_q, pend_d, mode_q, mode_d, pend_eff_s;
  logic          mv_q, mv_d, msof_q, msof_d, meol_q, meol_d;
  logic          fd_q, fd_d, err_q, err_d;
  logic [23:0]   mpix_q, mpix_d;
  logic          in_xfer_s, x_last_s, y_last_s;

  // Output byte order {hi,mid,lo} selected by mode; unused codes pass RGB through.
  function automatic logic [23:0] permute(input logic [2:0] mode, input logic [23:0] px);
    logic [7:0] r, g, b;
    r = px[23:16];
    g = px[15:8];
    b = px[7:0];
    case (mode)
      3'd1:    permute = {r, b, g};
      3'd2:    permute = {g, r, b};
      3'd3:    permute = {g, b, r};
      3'd4:    permute = {b, r, g};
      3'd5:    permute = {b, g, r};
      default: permute = {r, g, b};
    endcase
  endfunction

  assign s_ready     = !mv_q || m_ready;
  assign in_xfer_s   = s_valid && s_ready;
  assign x_last_s    = (x_q == XW'(H_PIX - 1));
  assign y_last_s    = (y_q == YW'(V_LINES - 1));
  assign pend_eff_s  = cfg_valid ? cfg_mode : pend_q;

  // Next-state: frame tracking, counters, output register load/drain and event pulses.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    mode_d  = mode_q;
    pend_d  = pend_eff_s;
    mpix_d  = mpix_q;
    msof_d  = msof_q;
    meol_d  = meol_q;
    fd_d    = 1'b0;
    err_d   = 1'b0;
    if (mv_q && m_ready) begin
      mv_d = 1'b0;
    end else begin
      mv_d = mv_q;
    end
    if (in_xfer_s) begin
      if (s_sof) begin
        // A sof always (re)starts the frame; inside an active frame it is a sync error.
        err_d   = (state_q == ST_ACTIVE);
        state_d = ST_ACTIVE;
        mode_d  = pend_eff_s;
        x_d     = XW'(1'b1);
        y_d     = YW'(1'b0);
        mv_d    = 1'b1;
        mpix_d  = permute(pend_eff_s, s_pixel);
        msof_d  = 1'b1;
        meol_d  = 1'b0;
      end else if (state_q == ST_ACTIVE) begin
        mv_d   = 1'b1;
        mpix_d = permute(mode_q, s_pixel);
        msof_d = (x_q == XW'(1'b0)) && (y_q == YW'(1'b0));
        meol_d = x_last_s;
        if (s_eol != x_last_s) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
          x_d     = XW'(1'b0);
          y_d     = YW'(1'b0);
        end else if (x_last_s && y_last_s) begin
          fd_d    = 1'b1;
          state_d = ST_IDLE;
          x_d     = XW'(1'b0);
          y_d     = YW'(1'b0);
        end else if (x_last_s) begin
          x_d = XW'(1'b0);
          y_d = y_q + YW'(1'b1);
        end else begin
          x_d = x_q + XW'(1'b1);
          y_d = y_q;
        end
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      y_q     <= '0;
      pend_q  <= 3'd0;
      mode_q  <= 3'd0;
      mv_q    <= 1'b0;
      mpix_q  <= 24'd0;
      msof_q  <= 1'b0;
      meol_q  <= 1'b0;
      fd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      pend_q  <= pend_d;
      mode_q  <= mode_d;
      mv_q    <= mv_d;
      mpix_q  <= mpix_d;
      msof_q  <= msof_d;
      meol_q  <= meol_d;
      fd_q    <= fd_d;
      err_q   <= err_d;
    end
  end

  assign m_pixel     = mpix_q;
  assign m_valid     = mv_q;
  assign m_sof       = msof_q;
  assign m_eol       = meol_q;
  assign mode_active = mode_q;
  assign busy        = (state_q == ST_ACTIVE);
  assign frame_done  = fd_q;
  assign err_sync    = err_q;
endmodule

// File: tb/tb_pixel_swap_ctrl.sv
// Bench for pixel_swap_ctrl: directed frames plus random traffic, checked every cycle
// against a frame-position reference model.
module tb_pixel_swap_ctrl;
  localparam int H = 4;
  localparam int V = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  cfg_mode = 3'd0;
  logic        cfg_valid = 1'b0;
  logic [23:0] s_pixel = 24'd0;
  logic        s_valid = 1'b0, s_sof = 1'b0, s_eol = 1'b0;
  logic        s_ready;
  logic [23:0] m_pixel;
  logic        m_valid, m_sof, m_eol;
  logic        m_ready = 1'b1;
  logic [2:0]  mode_active;
  logic        busy, frame_done, err_sync;

  int checks = 0;
  int errors = 0;
  int rdy_mode = 0;

  // reference model state: frame position as a flat pixel index
  bit          r_inf;
  int          r_pos;
  logic [2:0]  r_pend, r_act;
  bit          r_mv, r_msof, r_meol, r_err, r_fd;
  logic [23:0] r_pix;
  int          perm_tab [8][3] = '{'{0,1,2}, '{0,2,1}, '{1,0,2}, '{1,2,0},
                                   '{2,0,1}, '{2,1,0}, '{0,1,2}, '{0,1,2}};

  pixel_swap_ctrl #(.H_PIX(H), .V_LINES(V)) dut (
    .clk(clk), .rst(rst), .cfg_mode(cfg_mode), .cfg_valid(cfg_valid),
    .s_pixel(s_pixel), .s_valid(s_valid), .s_sof(s_sof), .s_eol(s_eol), .s_ready(s_ready),
    .m_pixel(m_pixel), .m_valid(m_valid), .m_sof(m_sof), .m_eol(m_eol), .m_ready(m_ready),
    .mode_active(mode_active), .busy(busy), .frame_done(frame_done), .err_sync(err_sync)
  );

  always #5 clk = ~clk;

  function automatic logic [23:0] ref_perm(input logic [2:0] mode, input logic [23:0] px);
    logic [7:0] ch [3];
    ch[0] = px[23:16];
    ch[1] = px[15:8];
    ch[2] = px[7:0];
    return {ch[perm_tab[mode][0]], ch[perm_tab[mode][1]], ch[perm_tab[mode][2]]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    r_inf = 0; r_pos = 0; r_pend = 3'd0; r_act = 3'd0;
    r_mv = 0; r_pix = 24'd0; r_msof = 0; r_meol = 0; r_err = 0; r_fd = 0;
  endtask

  // One clock: check outputs against the model, advance the model, cross the edge.
  task automatic step(output bit acc);
    bit exp_ready, fwd, last;
    logic [2:0] cp;
    case (rdy_mode)
      0:       m_ready = 1'b1;
      1:       m_ready = ~m_ready;
      3:       m_ready = 1'b0;
      default: m_ready = 1'($urandom_range(0, 1));
    endcase
    #1;
    exp_ready = !r_mv || m_ready;
    chk("s_ready", s_ready, exp_ready);
    chk("m_valid", m_valid, r_mv);
    chk("mode_active", mode_active, r_act);
    chk("busy", busy, r_inf);
    chk("frame_done", frame_done, r_fd);
    chk("err_sync", err_sync, r_err);
    if (r_mv) begin
      chk("m_pixel", m_pixel, r_pix);
      chk("m_sof", m_sof, r_msof);
      chk("m_eol", m_eol, r_meol);
    end
    acc = s_valid && exp_ready && !rst;
    if (rst) begin
      model_reset();
    end else begin
      r_err = 0; r_fd = 0; fwd = 0;
      cp = cfg_valid ? cfg_mode : r_pend;
      if (acc && s_sof) begin
        r_err = r_inf; r_inf = 1; r_act = cp; r_pos = 1;
        fwd = 1; r_pix = ref_perm(cp, s_pixel); r_msof = 1; r_meol = 0;
      end else if (acc && r_inf) begin
        last = (r_pos % H) == H - 1;
        fwd = 1; r_pix = ref_perm(r_act, s_pixel); r_msof = (r_pos == 0); r_meol = last;
        if (s_eol != last) begin
          r_err = 1; r_inf = 0; r_pos = 0;
        end else if (r_pos == H * V - 1) begin
          r_fd = 1; r_inf = 0; r_pos = 0;
        end else begin
          r_pos++;
        end
      end
      if (fwd) r_mv = 1;
      else if (r_mv && m_ready) r_mv = 0;
      r_pend = cp;
    end
    @(posedge clk);
    @(negedge clk);
    cfg_valid = 1'b0;
    rst = 1'b0;
  endtask

  task automatic push(input logic [23:0] px, input bit sof, input bit eol);
    bit acc;
    s_valid = 1'b1; s_pixel = px; s_sof = sof; s_eol = eol;
    acc = 0;
    for (int k = 0; k < 40; k++) begin
      step(acc);
      if (acc) break;
    end
    chk("accept_timeout", acc, 1'b1);
  endtask

  task automatic idle(input int n);
    bit acc;
    s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
    for (int k = 0; k < n; k++) step(acc);
  endtask

  task automatic send_frame(input logic [23:0] base);
    for (int i = 0; i < H * V; i++)
      push(base + 24'(i) * 24'h010101, i == 0, (i % H) == H - 1);
  endtask

  initial begin
    bit a;
    int gp;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst = 1'b0;
    idle(2);

    // frame with mode 1, always ready
    cfg_mode = 3'd1; cfg_valid = 1'b1;
    idle(1);
    send_frame(24'h112233);
    idle(3);

    // same frame with alternating downstream ready
    rdy_mode = 1;
    send_frame(24'h112233);
    idle(4);
    rdy_mode = 0;

    // mode change mid-frame only affects the next frame
    for (int i = 0; i < H * V; i++) begin
      if (i == 3) begin cfg_mode = 3'd5; cfg_valid = 1'b1; end
      push(24'h112233 + 24'(i), i == 0, (i % H) == H - 1);
    end
    idle(1);
    send_frame(24'hAABBCC);
    idle(2);

    // early eol at x=1, then sof-less pixels are dropped
    cfg_mode = 3'd2; cfg_valid = 1'b1;
    push(24'h010203, 1'b1, 1'b0);
    push(24'h040506, 1'b0, 1'b1);
    push(24'h070809, 1'b0, 1'b0);
    push(24'h0A0B0C, 1'b0, 1'b1);
    idle(2);

    // sof arriving at x=2,y=1 restarts the frame
    for (int i = 0; i < 6; i++) push(24'h200000 + 24'(i), i == 0, (i % H) == H - 1);
    for (int i = 0; i < H * V; i++) push(24'h300000 + 24'(i), i == 0, (i % H) == H - 1);
    idle(2);

    // reset while an output pixel is stalled
    rdy_mode = 3;
    push(24'h445566, 1'b1, 1'b0);
    idle(2);
    rst = 1'b1;
    idle(1);
    idle(2);
    rdy_mode = 0;

    // random traffic with occasional marker faults, config strobes and resets
    rdy_mode = 2;
    gp = 0;
    for (int c = 0; c < 600; c++) begin
      s_valid = ($urandom_range(0, 9) < 8);
      s_pixel = 24'($urandom);
      s_sof = (gp == 0) || ($urandom_range(0, 39) == 0);
      s_eol = ((gp % H) == H - 1) ^ ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 9) == 0) begin
        cfg_valid = 1'b1; cfg_mode = 3'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 149) == 0) rst = 1'b1;
      step(a);
      if (a) gp = s_sof ? 1 : (gp + 1) % (H * V);
    end
    rdy_mode = 0;
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pixel_swap_ctrl.md
PIXEL_SWAP_CTRL -- requirements
Module: pixel_swap_ctrl

Interface
REQ-001 Parameter H_PIX, default 1280, active pixels per line (>=2).
REQ-002 Parameter V_LINES, default 720, lines per frame (>=2).
REQ-003 clk  in  1  single system clock; all logic on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 cfg_mode  in  3  requested channel permutation.
REQ-006 cfg_valid  in  1  one-cycle strobe; captures cfg_mode as pending mode.
REQ-007 s_pixel  in  24  input pixel {R[23:16],G[15:8],B[7:0]}.
REQ-008 s_valid  in  1  input pixel valid.
REQ-009 s_sof  in  1  input start-of-frame marker, qualified by s_valid.
REQ-010 s_eol  in  1  input end-of-line marker, qualified by s_valid.
REQ-011 s_ready  out  1  block accepts input this cycle.
REQ-012 m_pixel  out  24  permuted output pixel.
REQ-013 m_valid  out  1  output pixel valid.
REQ-014 m_sof  out  1  output start-of-frame, regenerated from counters.
REQ-015 m_eol  out  1  output end-of-line, regenerated from counters.
REQ-016 m_ready  in  1  downstream accepts output.
REQ-017 mode_active  out  3  permutation applied to the current frame.
REQ-018 busy  out  1  high while state is ACTIVE.
REQ-019 frame_done  out  1  one-cycle pulse when last pixel of a frame is accepted.
REQ-020 err_sync  out  1  one-cycle pulse on marker mismatch.

Function
REQ-021 Input transfer = s_valid & s_ready; output transfer = m_valid & m_ready.
REQ-022 s_ready = !m_valid | m_ready (single output register, combinational ready).
REQ-023 Latency: accepted pixel appears on m_pixel the next cycle; m_pixel/m_sof/m_eol held stable while m_valid & !m_ready.
REQ-024 Permutation by mode_active, output {hi,mid,lo}: 0 RGB, 1 RBG, 2 GRB, 3 GBR, 4 BRG, 5 BGR, 6/7 RGB.
REQ-025 States: IDLE, ACTIVE.
REQ-026 IDLE: pixels with s_sof=0 accepted and discarded (s_ready=1 when output register empty); no m_valid.
REQ-027 IDLE -> ACTIVE on accepted pixel with s_sof=1; that pixel is x=0,y=0, forwarded with m_sof=1.
REQ-028 Pending mode copied to mode_active on the same edge that accepts the sof pixel; sof pixel uses the new mode.
REQ-029 cfg_valid any time updates pending only; mode_active never changes mid-frame.
REQ-030 cfg_valid coincident with sof acceptance: new cfg_mode applies to that frame.
REQ-031 Counters x (0..H_PIX-1), y (0..V_LINES-1) advance per accepted pixel; x wraps to 0 and y increments after x=H_PIX-1.
REQ-032 m_sof=1 iff x=0,y=0; m_eol=1 iff x=H_PIX-1.
REQ-033 Accepted pixel at x=H_PIX-1,y=V_LINES-1: frame_done pulses, state -> IDLE, counters -> 0.
REQ-034 s_eol != (x==H_PIX-1) on accepted pixel in ACTIVE: pixel forwarded, err_sync pulses, state -> IDLE.
REQ-035 s_sof=1 accepted in ACTIVE: err_sync pulses, frame restarts at x=0,y=0, pending mode applied, pixel forwarded with m_sof=1.
REQ-036 Case REQ-035 takes priority over REQ-034 on the same pixel; single err_sync pulse.
REQ-037 Back-pressure stalls counters; no pixel dropped or duplicated in ACTIVE.

Reset
REQ-038 rst=1: state IDLE, x=y=0, pending=0, mode_active=0, m_valid=0, m_pixel=0, m_sof=m_eol=0, busy=0, frame_done=0, err_sync=0.
REQ-039 rst mid-frame discards the held output pixel; first post-reset output requires a new sof.

Verification
REQ-040 H_PIX=4,V_LINES=2, cfg_mode=1, one frame 0x112233.. with m_ready=1 -> outputs 0x113322.., mode_active=1, m_eol on x=3, frame_done after 8th pixel, back to IDLE.
REQ-041 Same frame, m_ready toggled 1010.. -> all 8 pixels in order, each held stable while stalled, no loss.
REQ-042 cfg_valid mode=5 mid-frame -> remainder keeps old mode; next frame 0xAABBCC -> 0xCCBBAA.
REQ-043 s_eol at x=1 -> err_sync one pulse, busy=0, following pixels without sof discarded.
REQ-044 sof at x=2,y=1 -> err_sync pulse, m_sof=1 on that pixel, count restarts.
REQ-045 rst asserted while m_valid=1,m_ready=0 -> next cycle m_valid=0, mode_active=0, busy=0.
